pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic pipeline stage register; replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Adds per-stage valid/ready handshake, stall back-pressure, flush, bubble insertion and a stall counter.
//  Payload is split into a control field (sig, zeroed on bubble) and a data field (held on bubble).
//  One instance sits between each pair of adjacent pipeline stages.
// PARAMETERS
//  SIG_W   9   control-signal field width, >= 1
//  DATA_W  64  datapath payload width (concatenated PC/operands/reg ids), >= 1
//  CNT_W   16  stall-counter width, >= 1
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  flush      in   1       discard stored and incoming entry (branch/exception)
//  in_valid   in   1       upstream entry valid
//  in_ready   out  1       stage can accept this cycle
//  in_sig     in   SIG_W   upstream control bits
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       stored entry valid
//  out_ready  in   1       downstream accepts this cycle
//  out_sig    out  SIG_W   registered control bits; all-zero whenever out_valid=0
//  out_data   out  DATA_W  registered payload; held (not cleared) on bubble
//  stall_cnt  out  CNT_W   cycles with out_valid && !out_ready, saturating
// BEHAVIOUR
//  Reset (async, rst=1): out_valid=0, out_sig=0, out_data=0, stall_cnt=0; skid entry (if built) empty.
//  Transfer in:  in_valid && in_ready at posedge. Transfer out: out_valid && out_ready at posedge.
//  Latency 1 cycle in->out. Full throughput: one transfer/cycle with out_ready held 1.
//  Base (no skid): in_ready = !out_valid || out_ready (combinational from out_ready).
//   in_ready=1: out_valid<=in_valid; in_valid=1 -> load sig/data; in_valid=0 -> bubble (out_sig<=0, data held).
//   in_ready=0 (stall): all outputs hold.
//  flush=1: in_ready=1 that cycle; incoming entry is accepted and dropped; next cycle out_valid=0, out_sig=0.
//   flush overrides simultaneous load and simultaneous stall; out_ready ignored in flush cycle.
//  stall_cnt: +1 each cycle out_valid && !out_ready (flush cycles included); holds at 2^CNT_W-1; cleared only by rst.
//  Invariant: out_valid=0 -> out_sig=0 (checked by assertion).
//  rst asserted mid-transfer: entry lost, outputs to reset values immediately; no partial state survives.
// CONFIGURATION
//  PIPE_SKID_EN defined: second (skid) entry; in_ready is registered = !skid_valid (no out_ready->in_ready path).
//   Main full && !out_ready && transfer in -> entry goes to skid. out_ready with skid full: main<=skid, skid empties.
//   Order preserved (main always older). flush empties both entries. Full throughput maintained.
//  PIPE_SKID_EN undefined: single entry, combinational in_ready as above; no skid storage synthesised.
// STRUCTURE
//  Package pipe_pkg: localparam SIG_BUBBLE='0 semantics, typedef struct {valid,sig,data} for an entry,
//   function is_bubble(); shared by all stage instances and the hazard unit.
//  Sub-module pipe_stage_slot: one entry register (valid/sig/data) with load, hold and clear; instantiated
//   once (main) or twice (main + skid under PIPE_SKID_EN). Stall counter and control FSM in the top.
// TESTING (SIG_W=9, DATA_W=64, CNT_W=4; run both with and without PIPE_SKID_EN)
//  1 rst pulse mid-stream with out_valid=1 -> out_valid=0, out_sig=0, out_data=0, stall_cnt=0 same cycle.
//  2 stream 8 entries data=1..8, out_ready=1 -> outputs 1..8 on consecutive cycles, 1 cycle latency.
//  3 out_ready=0 for 3 cycles with entry 0x5 held -> out_data stays 0x5, stall_cnt=3, no loss/duplication.
//  4 flush while out_valid=1 and in_valid=1 (sig=0x1FF) -> next cycle out_valid=0, out_sig=0, in_ready=1.
//  5 in_valid=0 for 1 cycle -> bubble: out_valid=0, out_sig=0, out_data unchanged.
//  6 out_ready=0 for 20 cycles -> stall_cnt saturates at 15; skid build: in_ready falls 1 cycle after 2nd entry.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: bubble encoding, entry layout, control states.
// Imported by every stage register instance and by the hazard unit.
package pipe_pkg;

  localparam int DEF_SIG_W  = 9;
  localparam int DEF_DATA_W = 64;

  // Control field value of a bubble, replicated to the field width
  localparam bit SIG_BUBBLE = 1'b0;

  typedef struct packed {
    logic                  valid;
    logic [DEF_SIG_W-1:0]  sig;
    logic [DEF_DATA_W-1:0] data;
  } pipe_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_st_e;

  function automatic logic is_bubble(input logic valid);
    return !valid;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between adjacent pipeline stages.
// The producer side uses master, the consumer side uses slave.
interface pipe_stage_reg_if #(
  parameter int SIG_W  = 9,
  parameter int DATA_W = 64
);

  logic              valid;
  logic              ready;
  logic [SIG_W-1:0]  sig;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output sig,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  sig,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_stage_slot.sv
// One pipeline entry register (valid/sig/data) with load, hold and clear.
// A non-valid load or a clear zeroes the control field and keeps the data.
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int SIG_W  = 9,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [SIG_W-1:0]  sig_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [SIG_W-1:0]  sig_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    sig_d   = sig_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      sig_d   = {SIG_W{SIG_BUBBLE}};
    end else if (load_i) begin
      valid_d = valid_i;
      sig_d   = valid_i ? sig_i : {SIG_W{SIG_BUBBLE}};
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      sig_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      sig_q   <= sig_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign sig_o   = sig_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with handshake, flush, bubble, stall count.
// Define PIPE_SKID_EN for a second skid entry and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int SIG_W  = 9,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_v;
  logic [SIG_W-1:0]  main_sig;
  logic [DATA_W-1:0] main_data;
  logic              main_load;
  logic              main_vin;
  logic [SIG_W-1:0]  main_sin;
  logic [DATA_W-1:0] main_din;

`ifdef PIPE_SKID_EN
  pipe_st_e          st_q, st_d;
  logic              rdy_q;
  logic              from_skid;
  logic              skid_v;
  logic [SIG_W-1:0]  skid_sig;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;
  logic              skid_clear;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_EMPTY: if (up.valid) st_d = ST_ONE;
      ST_ONE: begin
        if (up.valid && !dn.ready)      st_d = ST_TWO;
        else if (!up.valid && dn.ready) st_d = ST_EMPTY;
      end
      ST_TWO: if (dn.ready) st_d = ST_ONE;
      default: st_d = ST_EMPTY;
    endcase
    if (flush) st_d = ST_EMPTY;
  end

  // in_ready comes from state only, cutting the out_ready -> in_ready path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= ST_EMPTY;
      rdy_q <= 1'b1;
    end else begin
      st_q  <= st_d;
      rdy_q <= (st_d != ST_TWO);
    end
  end

  assign up.ready   = rdy_q | flush;
  assign from_skid  = (st_q == ST_TWO);
  assign main_load  = !flush &&
                      (from_skid ? dn.ready
                                 : (st_q == ST_EMPTY || dn.ready));
  assign main_vin   = from_skid ? 1'b1 : up.valid;
  assign main_sin   = from_skid ? skid_sig : up.sig;
  assign main_din   = from_skid ? skid_data : up.data;
  assign skid_load  = !flush && st_q == ST_ONE && !dn.ready && up.valid;
  assign skid_clear = flush || (from_skid && dn.ready);

  pipe_stage_slot #(
    .SIG_W  (SIG_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .valid_i (1'b1),
    .sig_i   (up.sig),
    .data_i  (up.data),
    .valid_o (skid_v),
    .sig_o   (skid_sig),
    .data_o  (skid_data)
  );

  a_skid_state: assert property (@(posedge clk) disable iff (rst)
    (st_q == ST_TWO) == skid_v);
`else
  assign up.ready  = flush | !main_v | dn.ready;
  assign main_load = !flush && (!main_v || dn.ready);
  assign main_vin  = up.valid;
  assign main_sin  = up.sig;
  assign main_din  = up.data;
`endif

  pipe_stage_slot #(
    .SIG_W  (SIG_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (flush),
    .valid_i (main_vin),
    .sig_i   (main_sin),
    .data_i  (main_din),
    .valid_o (main_v),
    .sig_o   (main_sig),
    .data_o  (main_data)
  );

  assign dn.valid = main_v;
  assign dn.sig   = main_sig;
  assign dn.data  = main_data;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (main_v && !dn.ready && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;

  a_bubble_sig: assert property (@(posedge clk) disable iff (rst)
    is_bubble(dn.valid) |-> dn.sig == '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (with or without PIPE_SKID_EN).
// Scoreboard pairs every accepted entry with the entry leaving the stage.
module tb_pipe_stage_reg;

  localparam int SIG_W  = 9;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [SIG_W-1:0]  sig;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail = 0;
  exp_t sb[$];

  pipe_stage_reg_if #(.SIG_W(SIG_W), .DATA_W(DATA_W)) up ();
  pipe_stage_reg_if #(.SIG_W(SIG_W), .DATA_W(DATA_W)) dn ();

  pipe_stage_reg #(
    .SIG_W  (SIG_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .up        (up),
    .dn        (dn),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required end of test");
    $fatal(1);
  end

  // Scoreboard: flush and reset drop everything in flight
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (dn.valid && dn.ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: got data=%h, required no output",
                   dn.data);
        end else begin
          e = sb.pop_front();
          if (dn.data !== e.data || dn.sig !== e.sig) begin
            n_fail++;
            $display("FAIL sb_order: got sig=%h data=%h, required sig=%h data=%h",
                     dn.sig, dn.data, e.sig, e.data);
          end
        end
      end
      if (up.valid && up.ready) sb.push_back({up.sig, up.data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [SIG_W-1:0] s,
                       input logic [DATA_W-1:0] d);
    up.valid = v;
    up.sig   = s;
    up.data  = d;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    flush = 1'b0;
    dn.ready = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0);
    dn.ready = 1'b0;
    tick();
    n_checks++;
    if (dn.valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %0b, required 0", dn.valid);
    end
    n_checks++;
    if (dn.sig !== '0) begin
      n_fail++; $display("FAIL reset_sig: got %h, required 0", dn.sig);
    end
    n_checks++;
    if (dn.data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h, required 0", dn.data);
    end
    n_checks++;
    if (stall_cnt !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d, required 0", stall_cnt);
    end
    n_checks++;
    if (up.ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %0b, required 1", up.ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    dn.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, SIG_W'(i), DATA_W'(i));
      tick();
      n_checks++;
      if (dn.valid !== 1'b1 || dn.data !== DATA_W'(i)) begin
        n_fail++;
        $display("FAIL stream_latency: got valid=%0b data=%0d, required valid=1 data=%0d",
                 dn.valid, dn.data, i);
      end
    end
    drive(1'b0, '0, '0);
    tick();
  endtask

  task automatic test_bubble();
    dn.ready = 1'b1;
    drive(1'b1, 9'h0AB, 64'h11);
    tick();
    drive(1'b0, 9'h155, 64'hDEAD);
    tick();
    n_checks++;
    if (dn.valid !== 1'b0) begin
      n_fail++; $display("FAIL bubble_valid: got %0b, required 0", dn.valid);
    end
    n_checks++;
    if (dn.sig !== '0) begin
      n_fail++; $display("FAIL bubble_sig: got %h, required 0", dn.sig);
    end
    n_checks++;
    if (dn.data !== 64'h11) begin
      n_fail++; $display("FAIL bubble_data: got %h, required 11", dn.data);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    dn.ready = 1'b1;
    drive(1'b1, 9'h005, 64'h5);
    tick();
    drive(1'b0, '0, '0);
    dn.ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (dn.valid !== 1'b1 || dn.data !== 64'h5) begin
      n_fail++;
      $display("FAIL stall_hold: got valid=%0b data=%h, required valid=1 data=5",
               dn.valid, dn.data);
    end
    n_checks++;
    if (stall_cnt !== 4'd3) begin
      n_fail++; $display("FAIL stall_cnt3: got %0d, required 3", stall_cnt);
    end
    dn.ready = 1'b1;
    tick();
    n_checks++;
    if (dn.valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_dup: got valid=%0b, required 0", dn.valid);
    end
    n_checks++;
    if (stall_cnt !== 4'd3) begin
      n_fail++; $display("FAIL stall_cnt_hold: got %0d, required 3", stall_cnt);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    dn.ready = 1'b1;
    drive(1'b1, 9'h0AA, 64'h77);
    tick();
    drive(1'b1, 9'h1FF, 64'h99);
    flush = 1'b1;
    dn.ready = 1'b0;
    #1;
    n_checks++;
    if (up.ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_ready: got %0b, required 1", up.ready);
    end
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    n_checks++;
    if (dn.valid !== 1'b0 || dn.sig !== '0) begin
      n_fail++;
      $display("FAIL flush_out: got valid=%0b sig=%h, required valid=0 sig=0",
               dn.valid, dn.sig);
    end
    n_checks++;
    if (stall_cnt !== 4'd1) begin
      n_fail++; $display("FAIL flush_cnt: got %0d, required 1", stall_cnt);
    end
    n_checks++;
    if (up.ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_ready_after: got %0b, required 1", up.ready);
    end
    drive(1'b1, 9'h011, 64'hA1);
    tick();
    drive(1'b1, 9'h022, 64'hA2);
    tick();
    drive(1'b0, '0, '0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dn.ready = 1'b1;
    tick();
    n_checks++;
    if (dn.valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_both: got valid=%0b, required 0", dn.valid);
    end
  endtask

  task automatic test_saturate();
    logic exp_rdy;
`ifdef PIPE_SKID_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    apply_reset();
    drive(1'b1, 9'h031, 64'hE1);
    tick();
    drive(1'b1, 9'h032, 64'hE2);
    #1;
    n_checks++;
    if (up.ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL sat_ready1: got %0b, required %0b", up.ready, exp_rdy);
    end
    tick();
    drive(1'b0, '0, '0);
    n_checks++;
    if (up.ready !== 1'b0) begin
      n_fail++; $display("FAIL sat_ready2: got %0b, required 0", up.ready);
    end
    repeat (8) tick();
    n_checks++;
    if (stall_cnt !== 4'd9) begin
      n_fail++; $display("FAIL sat_cnt9: got %0d, required 9", stall_cnt);
    end
    repeat (11) tick();
    n_checks++;
    if (stall_cnt !== 4'd15) begin
      n_fail++; $display("FAIL sat_cnt15: got %0d, required 15", stall_cnt);
    end
    n_checks++;
    if (dn.data !== 64'hE1) begin
      n_fail++; $display("FAIL sat_data: got %h, required e1", dn.data);
    end
    dn.ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (dn.valid !== 1'b0 || stall_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_drain: got valid=%0b cnt=%0d, required valid=0 cnt=15",
               dn.valid, stall_cnt);
    end
  endtask

  task automatic test_reset_mid();
    dn.ready = 1'b1;
    drive(1'b1, 9'h0C3, 64'hBEEF);
    tick();
    drive(1'b1, 9'h0C4, 64'hCAFE);
    n_checks++;
    if (dn.valid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: got valid=%0b, required 1", dn.valid);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dn.valid !== 1'b0 || dn.sig !== '0 || dn.data !== '0 ||
        stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL rmid_async: got valid=%0b sig=%h data=%h cnt=%0d, required all 0",
               dn.valid, dn.sig, dn.data, stall_cnt);
    end
    drive(1'b0, '0, '0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   cyc = 0;
    logic pend = 1'b0;
    logic acc;
    while (sent < 40 && cyc < 2000) begin
      cyc++;
      dn.ready = ($urandom_range(0, 9) < 7);
      if (!pend) begin
        if ($urandom_range(0, 3) != 0) begin
          drive(1'b1, SIG_W'($urandom), {32'($urandom), 32'(sent)});
          pend = 1'b1;
        end else begin
          drive(1'b0, '0, '0);
        end
      end
      @(negedge clk);
      acc = up.valid && up.ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        pend = 1'b0;
      end
    end
    n_checks++;
    if (sent != 40) begin
      n_fail++; $display("FAIL b2b_budget: got %0d sent, required 40", sent);
    end
    drive(1'b0, '0, '0);
    dn.ready = 1'b1;
    for (int i = 0; i < 10 && dn.valid; i++) tick();
    tick();
    n_checks++;
    if (sb.size() != 0 || dn.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d pending valid=%0b, required 0 pending valid=0",
               sb.size(), dn.valid);
    end
  endtask

  initial begin
    dn.ready = 1'b0;
    drive(1'b0, '0, '0);
    test_reset();
    test_stream();
    test_bubble();
    test_stall();
    test_flush();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
